ahb_byte_master: RTL and testbench
==================================

// Module: ahb_byte_master
// PURPOSE
//  AHB-Lite initiator driven by a byte stream (UART RX/TX side of the SoC); the opposite end of the
//  AHB slaves on the data bus. Decodes host command frames (word read/write) into single AHB-Lite
//  transfers and returns status/read data as bytes. Used for host debug access and RAM loading
//  in place of, or arbitrated with, the core's dmem port.
// PARAMETERS
//  IDLE_TIMEOUT  100000  max clk cycles between frame bytes before the frame is dropped
//  HPROT_VAL     4'b0011 constant driven on hprot (data, privileged)
// PORTS
//  clk       in   1   clock; all logic on rising edge
//  rst       in   1   synchronous reset, active-high
//  rx_data   in   8   received byte
//  rx_valid  in   1   rx_data valid; byte consumed when rx_valid & rx_ready
//  rx_ready  out  1   block can accept a byte
//  tx_data   out  8   response byte
//  tx_valid  out  1   tx_data valid; held stable until tx_ready
//  tx_ready  in   1   sink accepts tx_data this cycle
//  haddr     out  32  AHB address, bits [1:0] always 0
//  htrans    out  2   IDLE=2'b00 or NONSEQ=2'b10 only
//  hwrite    out  1   1 = write
//  hsize     out  3   always 3'b010 (word)
//  hburst    out  3   always 3'b000 (SINGLE)
//  hprot     out  4   HPROT_VAL
//  hwdata    out  32  write data, valid in data phase
//  hrdata    in   32  read data, sampled when hready=1 in data phase
//  hready    in   1   bus ready
//  hresp     in   1   0=OKAY, 1=ERROR
//  busy      out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, tx_valid=0, tx_data=0, busy=0;
//   rx_ready=0 while rst=1. rst mid-frame or mid-transfer aborts unconditionally (bench owns bus reset).
//  Frame (multi-byte fields little-endian): 'W'(0x57) A0..A3 D0..D3 ; 'R'(0x52) A0..A3.
//  Responses: write OKAY -> 0x4B; read OKAY -> 0x4B R0..R3; ERROR -> 0x45; unknown cmd -> 0x3F.
//  FSM: IDLE -> CMD decode on first byte: W/R -> ADDR; other -> RESP(0x3F).
//   ADDR: collect 4 bytes (2-bit index), then W -> DATA, R -> BUS_A. DATA: collect 4 -> BUS_A.
//   BUS_A: htrans=NONSEQ, haddr/hwrite valid; held until a cycle with hready=1 -> BUS_D,
//    htrans returns to IDLE the following cycle (single transfers only, no back-to-back).
//   BUS_D: hwdata driven; wait hready=1; then hresp=0 -> RESP(0x4B) (read: latch hrdata),
//    hresp=1 -> RESP(0x45). ERROR first cycle (hready=0,hresp=1) ignored; decision only on hready=1.
//   RESP: tx_valid=1 with status byte until tx_ready; read OKAY -> RDATA else IDLE.
//   RDATA: send R0..R3 in order, each held until tx_ready; after R3 -> IDLE.
//  rx_ready=1 only in IDLE/ADDR/DATA; bytes arriving in other states are back-pressured, never lost.
//  Inter-byte timer: reset on each accepted byte, counts in ADDR/DATA; at IDLE_TIMEOUT-1 -> IDLE,
//   no response, no bus cycle. Timer saturates, width $clog2(IDLE_TIMEOUT+1).
//  Byte accept and timeout in same cycle: byte wins (timer clears).
//  Address bits [1:0] from host discarded (forced 0); no address range check here.
//  Latency: last frame byte -> htrans=NONSEQ next cycle; hready=1 in data phase -> tx_valid next cycle.
// STRUCTURE
//  ahb_pkg: HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, byte constants CMD_W/CMD_R/RSP_OK/
//   RSP_ERR/RSP_BAD, state enum abm_state_t.
//  Single module; no sub-module (counters and shift registers inline).
// TESTING (AHB slave BFM with programmable wait states/ERROR, byte driver/monitor)
//  1 Write: 57 10 00 00 00 EF BE AD DE, 0 waits -> one NONSEQ haddr=0x10 hwrite=1, hwdata=DEADBEEF; tx 4B
//  2 Read, 3 waits: 52 13 00 01 00, slave returns 0x12345678 -> haddr=0x00010010; tx 4B 78 56 34 12
//  3 ERROR: write to addr 0x20, slave 2-cycle ERROR -> tx 45 only; next frame handled normally
//  4 Bad cmd 0xAA -> tx 3F, no htrans activity; tx_ready held low 5 cycles -> byte held stable
//  5 Timeout: 52 00 then silence IDLE_TIMEOUT cycles (IDLE_TIMEOUT=16) -> busy=0, no tx, no bus cycle
//  6 rst pulse during BUS_D and during RDATA -> outputs at reset values next cycle; new frame works

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, host protocol bytes and the state type
// for the byte-stream AHB initiator.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_BUS_A = 3'd3,
    ST_BUS_D = 3'd4,
    ST_RESP  = 3'd5,
    ST_RDATA = 3'd6
  } abm_state_t;

endpackage

// File: rtl/ahb_byte_master.sv
// Host byte-frame decoder issuing single AHB-Lite word transfers and
// streaming status / read data back as bytes.
module ahb_byte_master
  import ahb_pkg::*;
#(
  parameter int          IDLE_TIMEOUT = 100000,
  parameter logic [3:0]  HPROT_VAL    = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        busy
);

  localparam int              TW         = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMER_MAX  = TW'(IDLE_TIMEOUT);

  abm_state_t    r_state;
  logic          r_is_write;
  logic [1:0]    r_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_rd_ok;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic [1:0]    r_htrans;
  logic [31:0]   r_haddr;
  logic          r_hwrite;
  logic [31:0]   r_hwdata;

  logic w_collect;
  logic w_rx_ready;
  logic w_rx_fire;
  logic w_timeout;
  logic w_last_byte;

  assign w_collect   = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_rx_ready  = !rst && ((r_state == ST_IDLE) || w_collect);
  assign w_rx_fire   = w_rx_ready && rx_valid;
  assign w_timeout   = w_collect && (r_timer == TIMER_LAST);
  assign w_last_byte = (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_idx      <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rd_ok    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_htrans   <= HTRANS_IDLE;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hwdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            r_idx <= 2'd0;
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              r_is_write <= (rx_data == CMD_W);
              r_state    <= ST_ADDR;
            end else begin
              r_tx_data  <= RSP_BAD;
              r_tx_valid <= 1'b1;
              r_rd_ok    <= 1'b0;
              r_state    <= ST_RESP;
            end
          end
        end

        // Fields arrive LSB first, so each byte shifts in from the top.
        ST_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {rx_data, r_addr[31:8]};
            r_idx  <= r_idx + 2'd1;
            if (w_last_byte) begin
              if (r_is_write) begin
                r_state <= ST_DATA;
              end else begin
                r_state  <= ST_BUS_A;
                r_htrans <= HTRANS_NONSEQ;
                r_haddr  <= {rx_data, r_addr[31:10], 2'b00};
                r_hwrite <= 1'b0;
              end
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end
        end

        ST_DATA: begin
          if (w_rx_fire) begin
            r_wdata <= {rx_data, r_wdata[31:8]};
            r_idx   <= r_idx + 2'd1;
            if (w_last_byte) begin
              r_state  <= ST_BUS_A;
              r_htrans <= HTRANS_NONSEQ;
              r_haddr  <= {r_addr[31:2], 2'b00};
              r_hwrite <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end
        end

        ST_BUS_A: begin
          if (hready) begin
            r_htrans <= HTRANS_IDLE;
            r_hwdata <= r_wdata;
            r_state  <= ST_BUS_D;
          end
        end

        // An ERROR response's first (hready=0) cycle is simply another wait.
        ST_BUS_D: begin
          if (hready) begin
            r_tx_valid <= 1'b1;
            r_state    <= ST_RESP;
            if (hresp) begin
              r_tx_data <= RSP_ERR;
              r_rd_ok   <= 1'b0;
            end else begin
              r_tx_data <= RSP_OK;
              r_rd_ok   <= !r_hwrite;
              if (!r_hwrite) r_rdata <= hrdata;
            end
          end
        end

        ST_RESP: begin
          if (tx_ready) begin
            if (r_rd_ok) begin
              r_tx_data <= r_rdata[7:0];
              r_rdata   <= {8'h00, r_rdata[31:8]};
              r_idx     <= 2'd0;
              r_state   <= ST_RDATA;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        ST_RDATA: begin
          if (tx_ready) begin
            r_idx <= r_idx + 2'd1;
            if (w_last_byte) begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_tx_data <= r_rdata[7:0];
              r_rdata   <= {8'h00, r_rdata[31:8]};
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Inter-byte timer: only runs while a frame is being collected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_collect && !w_rx_fire) begin
      if (r_timer != TIMER_MAX) r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  assign rx_ready = w_rx_ready;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign haddr    = r_haddr;
  assign htrans   = r_htrans;
  assign hwrite   = r_hwrite;
  assign hsize    = HSIZE_WORD;
  assign hburst   = HBURST_SINGLE;
  assign hprot    = HPROT_VAL;
  assign hwdata   = r_hwdata;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ahb_byte_master.sv
// Randomised scoreboard bench for ahb_byte_master: byte driver, AHB slave
// model with wait states / ERROR, and a transmit-side monitor.
module tb_ahb_byte_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        busy;

  ahb_byte_master #(.IDLE_TIMEOUT(TO), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t      exp_bus[$];
  logic [7:0] exp_tx[$];

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen = 0;
  bit tx_hold = 1'b0;
  bit in_data = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Transmit sink: random backpressure unless held off.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Transmit monitor: pops expected bytes and checks hold-while-stalled.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("tx_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got %02h expected nothing", tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
            $display("[TB] tx byte %02h", tx_data);
          end
          tx_seen++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // AHB slave model: pops the expected transfer on each address phase.
  initial begin
    xfer_t cur;
    bit    aborted;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && htrans == 2'b10) begin
        if (exp_bus.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bus_unexpected: got haddr %08h expected no transfer", haddr);
          cur = '{addr: haddr, wr: hwrite, wdata: hwdata, waits: 0, err: 1'b0, rdata: 32'h0};
        end else begin
          cur = exp_bus.pop_front();
          chk("haddr", haddr, cur.addr);
          chk("hwrite", {31'd0, hwrite}, {31'd0, cur.wr});
        end
        chk("hsize", {29'd0, hsize}, 32'd2);
        chk("hburst", {29'd0, hburst}, 32'd0);
        chk("hprot", {28'd0, hprot}, 32'd3);
        @(posedge clk);
        #1;
        in_data = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < cur.waits && !aborted; i++) begin
          hready = 1'b0;
          hresp  = 1'b0;
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else chk("no_back_to_back", {30'd0, htrans}, 32'd0);
          @(posedge clk);
          #1;
        end
        if (!aborted && cur.err) begin
          hready = 1'b0;
          hresp  = 1'b1;
          @(negedge clk);
          if (rst) aborted = 1'b1;
          @(posedge clk);
          #1;
        end
        if (!aborted) begin
          hready = 1'b1;
          hresp  = cur.err;
          hrdata = cur.rdata;
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else if (cur.wr) chk("hwdata", hwdata, cur.wdata);
          @(posedge clk);
          #1;
          if (!aborted && !rst) chk("tx_latency", {31'd0, tx_valid}, 32'd1);
          $display("[TB] bus %s addr=%08h err=%0d", cur.wr ? "WR" : "RD", cur.addr, cur.err);
        end
        hready  = 1'b1;
        hresp   = 1'b0;
        hrdata  = $urandom;
        in_data = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) fail_now("rx_accept");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Reference model: expected bus transfer and response bytes per frame.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int waits,
                            input bit err, input logic [31:0] rdata);
    bit is_w, is_r;
    is_w = (cmd == 8'h57);
    is_r = (cmd == 8'h52);
    if (is_w || is_r) begin
      exp_bus.push_back('{addr: addr & 32'hFFFF_FFFC, wr: is_w, wdata: data,
                          waits: waits, err: err, rdata: rdata});
      if (err) begin
        exp_tx.push_back(8'h45);
      end else begin
        exp_tx.push_back(8'h4B);
        if (is_r) for (int i = 0; i < 4; i++) exp_tx.push_back(8'((rdata >> (8 * i)) & 32'hFF));
      end
    end else begin
      exp_tx.push_back(8'h3F);
    end
    $display("[TB] frame cmd=%02h addr=%08h data=%08h waits=%0d err=%0d", cmd, addr, data, waits, err);
    send_byte(cmd);
    if (is_w || is_r) begin
      for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) & 32'hFF));
      if (is_w) for (int i = 0; i < 4; i++) send_byte(8'((data >> (8 * i)) & 32'hFF));
      chk("nonseq_latency", {30'd0, htrans}, 32'h2);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) fail_now("frame_complete");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_tx.delete();
    exp_bus.delete();
    check_reset_outputs();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] c;
    int         n;
    int         base;
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Directed: write, waited read, ERROR, bad command.
    send_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    wait_done();
    send_frame(8'h52, 32'h0001_0013, 32'h0, 3, 1'b0, 32'h1234_5678);
    wait_done();
    send_frame(8'h57, 32'h0000_0020, 32'hCAFE_F00D, 0, 1'b1, 32'h0);
    send_frame(8'h52, 32'h0000_0024, 32'h0, 1, 1'b0, 32'hA5C3_0F81);
    wait_done();
    tx_hold = 1'b1;
    send_frame(8'hAA, 32'h0, 32'h0, 0, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    tx_hold = 1'b0;
    wait_done();

    // Inter-byte timeout: partial read frame, then silence.
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("timeout_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("timeout_busy_after", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_no_tx", {31'd0, tx_valid}, 32'd0);
    send_frame(8'h52, 32'h0000_0100, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    wait_done();

    // Reset while the slave is stalling the data phase.
    send_frame(8'h52, 32'h0000_0200, 32'h0, 8, 1'b0, 32'h1111_2222);
    n = 0;
    while (!in_data && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_data) fail_now("reach_data_phase");
    repeat (2) @(posedge clk);
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    send_frame(8'h57, 32'h0000_0300, 32'h0102_0304, 0, 1'b0, 32'h0);
    wait_done();

    // Reset while read bytes are streaming out.
    base = tx_seen;
    send_frame(8'h52, 32'h0000_0304, 32'h0, 0, 1'b0, 32'h8899_AABB);
    n = 0;
    while (tx_seen < base + 2 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (tx_seen < base + 2) fail_now("reach_rdata");
    do_reset();
    send_frame(8'h52, 32'h0000_0308, 32'h0, 2, 1'b0, 32'hFEDC_BA98);
    wait_done();

    // Randomised frames, sometimes issued back-to-back while busy.
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 9))
        0: begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
        end
        1, 2, 3, 4: c = 8'h57;
        default: c = 8'h52;
      endcase
      send_frame(c, $urandom, $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0), $urandom);
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
